// File: rtl/canv_pix_reader_pkg.sv
// canv_pix_reader_pkg: shared canvas FSM states, legal bpp codes and bpp helpers
package canv_pix_reader_pkg;
    typedef enum logic [2:0] {S_IDLE, S_CALC, S_ISSUE, S_WAIT, S_RESP} state_t;
    localparam logic [3:0] BPP1 = 4'd1;
    localparam logic [3:0] BPP2 = 4'd2;
    localparam logic [3:0] BPP4 = 4'd4;
    localparam logic [3:0] BPP8 = 4'd8;
    function automatic logic [3:0] bpp_norm(input logic [3:0] bpp);
        return (bpp == BPP1 || bpp == BPP2 || bpp == BPP8) ? bpp : BPP4;
    endfunction
    function automatic logic [2:0] bpp_shift(input logic [3:0] bpp);
        return bpp == BPP1 ? 3'd5 : bpp == BPP2 ? 3'd4 : bpp == BPP8 ? 3'd2 : 3'd3;
    endfunction
endpackage

// File: rtl/canv_pix_sel.sv
// canv_pix_sel: extracts one colour index from a packed vram word, pixel 0 in the LSBs
module canv_pix_sel
    import canv_pix_reader_pkg::*;
#(
    parameter int WORD  = 32,
    parameter int COLRW = 8
) (
    input  logic [WORD-1:0]  i_word,
    input  logic [7:0]       i_pix_id,
    input  logic [3:0]       i_bpp,
    output logic [COLRW-1:0] o_cidx
);
    logic [3:0]      w_bpp;
    logic [11:0]     w_off;
    logic [WORD-1:0] w_mask;
    assign w_bpp  = bpp_norm(i_bpp);
    assign w_off  = {4'd0, i_pix_id} * {8'd0, w_bpp};
    assign w_mask = (WORD'(1) << w_bpp) - WORD'(1);
    assign o_cidx = COLRW'((i_word >> w_off) & w_mask);
endmodule

// File: rtl/canv_pix_reader.sv
// canv_pix_reader: single-request vram pixel reader returning a colour index or out-of-bounds flag
module canv_pix_reader
    import canv_pix_reader_pkg::*;
#(
    parameter int CORDW    = 16,
    parameter int WORD     = 32,
    parameter int ADDRW    = 14,
    parameter int SHIFTW   = 3,
    parameter int COLRW    = 8,
    parameter int VRAM_LAT = 2
) (
    input  logic              clk_sys,
    input  logic              rst_sys,
    input  logic [CORDW-1:0]  canv_w,
    input  logic [CORDW-1:0]  canv_h,
    input  logic [3:0]        canv_bpp,
    input  logic [ADDRW-1:0]  addr_base,
    input  logic [SHIFTW-1:0] addr_shift,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [CORDW-1:0]  req_x,
    input  logic [CORDW-1:0]  req_y,
    output logic              vram_re,
    output logic [ADDRW-1:0]  vram_addr,
    input  logic [WORD-1:0]   vram_dout,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [COLRW-1:0]  rsp_cidx,
    output logic              rsp_oob,
    output logic              busy
);
    localparam int LW   = 2 * CORDW;
    localparam int CNTW = $clog2(VRAM_LAT + 1);
    state_t            r_state;
    logic [CORDW-1:0]  r_x, r_y, r_w, r_h;
    logic [3:0]        r_bpp;
    logic [ADDRW-1:0]  r_base, r_addr;
    logic [SHIFTW-1:0] r_shift;
    logic [7:0]        r_pix;
    logic [CNTW-1:0]   r_cnt;
    logic              r_re, r_rsp_valid, r_oob;
    logic [COLRW-1:0]  r_cidx;
    logic              w_oob;
    logic [LW-1:0]     w_linear;
    logic [ADDRW-1:0]  w_addr;
    logic [7:0]        w_pix;
    logic [COLRW-1:0]  w_cidx;
    assign w_oob    = r_x[CORDW-1] | r_y[CORDW-1] | (r_x >= r_w) | (r_y >= r_h);
    assign w_linear = LW'(r_y) * LW'(r_w) + LW'(r_x);
    assign w_addr   = r_base + ADDRW'(w_linear >> r_shift);
    assign w_pix    = 8'(w_linear) & ((8'd1 << r_shift) - 8'd1);
    canv_pix_sel #(.WORD(WORD), .COLRW(COLRW)) u_sel (
        .i_word   (vram_dout),
        .i_pix_id (r_pix),
        .i_bpp    (r_bpp),
        .o_cidx   (w_cidx)
    );
    // address and read strobe are registered on leaving CALC so vram_re lands two cycles after acceptance
    always_ff @(posedge clk_sys or posedge rst_sys) begin
        if (rst_sys) begin
            r_state     <= S_IDLE;
            r_x         <= '0;
            r_y         <= '0;
            r_w         <= '0;
            r_h         <= '0;
            r_bpp       <= '0;
            r_base      <= '0;
            r_shift     <= '0;
            r_pix       <= '0;
            r_cnt       <= '0;
            r_re        <= 1'b0;
            r_addr      <= '0;
            r_rsp_valid <= 1'b0;
            r_cidx      <= '0;
            r_oob       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (req_valid) begin
                    r_x     <= req_x;
                    r_y     <= req_y;
                    r_w     <= canv_w;
                    r_h     <= canv_h;
                    r_bpp   <= canv_bpp;
                    r_base  <= addr_base;
                    r_shift <= addr_shift;
                    r_state <= S_CALC;
                end
                S_CALC: if (w_oob) begin
                    r_oob       <= 1'b1;
                    r_cidx      <= '0;
                    r_rsp_valid <= 1'b1;
                    r_state     <= S_RESP;
                end else begin
                    r_addr  <= w_addr;
                    r_pix   <= w_pix;
                    r_re    <= 1'b1;
                    r_state <= S_ISSUE;
                end
                S_ISSUE: begin
                    r_re    <= 1'b0;
                    r_cnt   <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: if (r_cnt == CNTW'(VRAM_LAT - 1)) begin
                    r_cidx      <= w_cidx;
                    r_oob       <= 1'b0;
                    r_rsp_valid <= 1'b1;
                    r_state     <= S_RESP;
                end else begin
                    r_cnt <= r_cnt + CNTW'(1);
                end
                S_RESP: if (rsp_ready) begin
                    r_rsp_valid <= 1'b0;
                    r_state     <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
    assign req_ready = r_state == S_IDLE;
    assign busy      = r_state != S_IDLE;
    assign vram_re   = r_re;
    assign vram_addr = r_addr;
    assign rsp_valid = r_rsp_valid;
    assign rsp_cidx  = r_cidx;
    assign rsp_oob   = r_oob;
endmodule

// File: tb/tb_canv_pix_reader.sv
// tb_canv_pix_reader: directed cycle-accurate checks of the vram pixel reader
module tb_canv_pix_reader;
    logic        clk_sys = 1'b0;
    logic        rst_sys = 1'b1;
    logic [15:0] canv_w = 16'd320, canv_h = 16'd240;
    logic [3:0]  canv_bpp = 4'd4;
    logic [13:0] addr_base = '0;
    logic [2:0]  addr_shift = 3'd3;
    logic        req_valid = 1'b0, req_ready;
    logic [15:0] req_x = '0, req_y = '0;
    logic        vram_re;
    logic [13:0] vram_addr;
    logic [31:0] vram_dout = '0;
    logic        rsp_valid, rsp_ready = 1'b1;
    logic [7:0]  rsp_cidx;
    logic        rsp_oob, busy;
    int          n_tests = 0, n_fail = 0, re_cnt = 0;
    logic [31:0] mem_word = '0, p1 = '0;

    canv_pix_reader dut (
        .clk_sys(clk_sys), .rst_sys(rst_sys), .canv_w(canv_w), .canv_h(canv_h),
        .canv_bpp(canv_bpp), .addr_base(addr_base), .addr_shift(addr_shift),
        .req_valid(req_valid), .req_ready(req_ready), .req_x(req_x), .req_y(req_y),
        .vram_re(vram_re), .vram_addr(vram_addr), .vram_dout(vram_dout),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_cidx(rsp_cidx),
        .rsp_oob(rsp_oob), .busy(busy)
    );

    always #5 clk_sys = ~clk_sys;

    // two-stage vram model: data is only valid in the one cycle VRAM_LAT after the read
    always @(posedge clk_sys) begin
        if (vram_re) re_cnt <= re_cnt + 1;
        p1        <= vram_re ? mem_word : 32'hDEADBEEF;
        vram_dout <= p1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic setup(input logic [15:0] w, input logic [15:0] h, input logic [3:0] bpp,
                         input logic [13:0] base, input logic [2:0] sh);
        canv_w = w; canv_h = h; canv_bpp = bpp; addr_base = base; addr_shift = sh;
    endtask

    task automatic start(input logic [15:0] x, input logic [15:0] y);
        chk("req_ready_before_accept", {31'd0, req_ready}, 1);
        req_x = x; req_y = y; req_valid = 1'b1;
        @(posedge clk_sys);
        #1 req_valid = 1'b0;
    endtask

    task automatic inb(input logic [15:0] x, input logic [15:0] y, input logic [31:0] word,
                       input logic [13:0] exp_addr, input logic [7:0] exp_cidx);
        int c0;
        logic [15:0] sw, sh;
        logic [3:0]  sb;
        logic [13:0] sa;
        logic [2:0]  ss;
        sw = canv_w; sh = canv_h; sb = canv_bpp; sa = addr_base; ss = addr_shift;
        mem_word = word;
        c0 = re_cnt;
        start(x, y);
        setup(16'd1, 16'd1, 4'd1, 14'h1234, 3'd0);
        @(negedge clk_sys);
        chk("calc_re", {31'd0, vram_re}, 0);
        chk("calc_busy", {31'd0, busy}, 1);
        chk("calc_req_ready", {31'd0, req_ready}, 0);
        @(negedge clk_sys);
        chk("issue_re", {31'd0, vram_re}, 1);
        chk("issue_addr", {18'd0, vram_addr}, {18'd0, exp_addr});
        @(negedge clk_sys);
        chk("wait1_re", {31'd0, vram_re}, 0);
        chk("wait1_valid", {31'd0, rsp_valid}, 0);
        @(negedge clk_sys);
        chk("wait2_valid", {31'd0, rsp_valid}, 0);
        @(negedge clk_sys);
        chk("rsp_valid", {31'd0, rsp_valid}, 1);
        chk("rsp_cidx", {24'd0, rsp_cidx}, {24'd0, exp_cidx});
        chk("rsp_oob", {31'd0, rsp_oob}, 0);
        chk("re_pulses", re_cnt - c0, 1);
        setup(sw, sh, sb, sa, ss);
    endtask

    task automatic oob(input logic [15:0] x, input logic [15:0] y);
        int c0;
        c0 = re_cnt;
        start(x, y);
        @(negedge clk_sys);
        chk("oob_calc_valid", {31'd0, rsp_valid}, 0);
        @(negedge clk_sys);
        chk("oob_valid", {31'd0, rsp_valid}, 1);
        chk("oob_flag", {31'd0, rsp_oob}, 1);
        chk("oob_cidx", {24'd0, rsp_cidx}, 0);
        chk("oob_no_re", re_cnt - c0, 0);
    endtask

    task automatic done();
        rsp_ready = 1'b1;
        @(negedge clk_sys);
        chk("post_rsp_valid", {31'd0, rsp_valid}, 0);
        chk("post_req_ready", {31'd0, req_ready}, 1);
        chk("post_busy", {31'd0, busy}, 0);
    endtask

    initial begin
        #2;
        chk("rst_req_ready", {31'd0, req_ready}, 1);
        chk("rst_re", {31'd0, vram_re}, 0);
        chk("rst_addr", {18'd0, vram_addr}, 0);
        chk("rst_valid", {31'd0, rsp_valid}, 0);
        chk("rst_cidx", {24'd0, rsp_cidx}, 0);
        chk("rst_oob", {31'd0, rsp_oob}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        @(negedge clk_sys) rst_sys = 1'b0;
        @(negedge clk_sys);
        setup(16'd320, 16'd240, 4'd4, 14'd0, 3'd3);
        inb(16'd3, 16'd1, 32'h0000A000, 14'd40, 8'hA); done();
        oob(16'd320, 16'd0); done();
        oob(16'hFFFF, 16'd5); done();
        oob(16'd0, 16'd240); done();
        setup(16'd320, 16'd240, 4'd1, 14'd0, 3'd5);
        inb(16'd31, 16'd0, 32'h80000000, 14'd0, 8'h01); done();
        setup(16'd320, 16'd240, 4'd8, 14'd0, 3'd2);
        inb(16'd5, 16'd0, 32'h00007700, 14'd1, 8'h77); done();
        setup(16'd320, 16'd240, 4'd2, 14'd0, 3'd4);
        inb(16'd17, 16'd0, 32'h0000000C, 14'd1, 8'h03); done();
        setup(16'd320, 16'd240, 4'd3, 14'd0, 3'd3);
        inb(16'd1, 16'd0, 32'h000000B0, 14'd0, 8'h0B); done();
        setup(16'd320, 16'd240, 4'd4, 14'h3FFF, 3'd3);
        inb(16'd32, 16'd0, 32'h00000005, 14'd3, 8'h05); done();
        setup(16'd320, 16'd240, 4'd4, 14'd0, 3'd3);
        rsp_ready = 1'b0;
        inb(16'd3, 16'd1, 32'h0000A000, 14'd40, 8'hA);
        for (int i = 0; i < 5; i++) begin
            req_valid = (i == 1);
            req_x = 16'd0; req_y = 16'd0;
            @(negedge clk_sys);
            chk("bp_valid", {31'd0, rsp_valid}, 1);
            chk("bp_cidx", {24'd0, rsp_cidx}, 32'hA);
            chk("bp_oob", {31'd0, rsp_oob}, 0);
            chk("bp_req_ready", {31'd0, req_ready}, 0);
        end
        req_valid = 1'b0;
        done();
        inb(16'd5, 16'd0, 32'h00300000, 14'd0, 8'h03); done();
        mem_word = 32'h0000A000;
        start(16'd3, 16'd1);
        repeat (3) @(negedge clk_sys);
        #1 rst_sys = 1'b1;
        #1;
        chk("mid_rst_re", {31'd0, vram_re}, 0);
        chk("mid_rst_addr", {18'd0, vram_addr}, 0);
        chk("mid_rst_valid", {31'd0, rsp_valid}, 0);
        chk("mid_rst_cidx", {24'd0, rsp_cidx}, 0);
        chk("mid_rst_busy", {31'd0, busy}, 0);
        chk("mid_rst_req_ready", {31'd0, req_ready}, 1);
        @(negedge clk_sys) rst_sys = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_sys);
            chk("after_rst_valid", {31'd0, rsp_valid}, 0);
            chk("after_rst_re", {31'd0, vram_re}, 0);
        end
        inb(16'd3, 16'd1, 32'h0000A000, 14'd40, 8'hA); done();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
